// File: rtl/btc_nonce_sched.sv
// rtl/btc_nonce_sched.sv - double-SHA256 nonce sweep scheduler for an external hash core
//
// Walks an inclusive 32-bit nonce range. Each nonce gets two passes on the core:
// pass 0 hashes the header and pass 1 rehashes that digest. The second digest is
// then checked for a required number of leading zero bits.
//
// Ports
//   wb_clk_i      in   1    clock, all state changes on the rising edge
//   rst_n         in   1    asynchronous active-low reset
//   start         in   1    begin a sweep (accepted only in IDLE, and only without stop)
//   stop          in   1    abort the running sweep (ignored in IDLE)
//   nonce_first   in   32   first nonce of the range, sampled on accepted start
//   nonce_last    in   32   last nonce of the range (inclusive), sampled on accepted start
//   target_zeros  in   8    required leading-zero bits of the final digest
//   core_start    out  1    one-cycle launch of a core pass
//   core_pass     out  1    0 = header hash, 1 = rehash of the previous digest
//   core_nonce    out  32   nonce under test, stable for the whole double hash
//   core_done     in   1    pass-complete pulse from the core
//   core_digest   in   256  pass result, valid with core_done
//   busy          out  1    high in every state except IDLE
//   done          out  1    one-cycle pulse when a sweep ends (hit, exhausted, stop, timeout)
//   found         out  1    a digest met the target
//   aborted       out  1    sweep ended by stop
//   error         out  1    core did not answer within TIMEOUT cycles
//   found_nonce   out  32   nonce that produced the hit
//   hash_count    out  32   completed double hashes in the current/last sweep
`timescale 1ns/1ps

module btc_nonce_sched #(
  parameter int TIMEOUT = 1024
) (
  input  logic         wb_clk_i,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic [31:0]  nonce_first,
  input  logic [31:0]  nonce_last,
  input  logic [7:0]   target_zeros,
  output logic         core_start,
  output logic         core_pass,
  output logic [31:0]  core_nonce,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         aborted,
  output logic         error,
  output logic [31:0]  found_nonce,
  output logic [31:0]  hash_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH1,
    WAIT1,
    LAUNCH2,
    WAIT2,
    CHECK
  } state_t;

  state_t         state;
  logic [31:0]    last_q;
  logic [7:0]     tz_q;
  logic [255:0]   digest_q;
  logic [TW-1:0]  tmo_cnt;
  logic [255:0]   zero_mask;
  logic           hit;

  // Mask covers the top target_zeros bits; target_zeros=0 gives an empty mask,
  // so every digest hits.
  always_comb begin
    zero_mask = ~({256{1'b1}} >> tz_q);
    hit       = ~|(digest_q & zero_mask);
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_q      <= '0;
      tz_q        <= '0;
      digest_q    <= '0;
      tmo_cnt     <= '0;
      core_start  <= 1'b0;
      core_pass   <= 1'b0;
      core_nonce  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      aborted     <= 1'b0;
      error       <= 1'b0;
      found_nonce <= '0;
      hash_count  <= '0;
    end else begin
      // Pulse outputs default low; they are raised only on the cycle that needs them.
      core_start <= 1'b0;
      done       <= 1'b0;

      if (state != IDLE && stop) begin
        // Abort wins over a core_done arriving in the same cycle: the result is dropped.
        aborted   <= 1'b1;
        done      <= 1'b1;
        busy      <= 1'b0;
        core_pass <= 1'b0;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              last_q     <= nonce_last;
              tz_q       <= target_zeros;
              core_nonce <= nonce_first;
              found      <= 1'b0;
              aborted    <= 1'b0;
              error      <= 1'b0;
              hash_count <= '0;
              busy       <= 1'b1;
              core_start <= 1'b1;
              core_pass  <= 1'b0;
              state      <= LAUNCH1;
            end
          end

          LAUNCH1: begin
            tmo_cnt <= '0;
            state   <= WAIT1;
          end

          WAIT1: begin
            if (core_done) begin
              core_start <= 1'b1;
              core_pass  <= 1'b1;
              state      <= LAUNCH2;
            end else if (tmo_cnt == TMO_LAST) begin
              error     <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              core_pass <= 1'b0;
              state     <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end

          LAUNCH2: begin
            tmo_cnt <= '0;
            state   <= WAIT2;
          end

          WAIT2: begin
            if (core_done) begin
              digest_q   <= core_digest;
              hash_count <= hash_count + 32'd1;
              state      <= CHECK;
            end else if (tmo_cnt == TMO_LAST) begin
              error     <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              core_pass <= 1'b0;
              state     <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end

          CHECK: begin
            if (hit) begin
              found       <= 1'b1;
              found_nonce <= core_nonce;
              done        <= 1'b1;
              busy        <= 1'b0;
              core_pass   <= 1'b0;
              state       <= IDLE;
            end else if (core_nonce == last_q) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              core_pass <= 1'b0;
              state     <= IDLE;
            end else begin
              // Natural 32-bit wrap lets a range with last < first sweep through zero.
              core_nonce <= core_nonce + 32'd1;
              core_start <= 1'b1;
              core_pass  <= 1'b0;
              state      <= LAUNCH1;
            end
          end

          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btc_nonce_sched.sv
// tb/tb_btc_nonce_sched.sv - directed table-driven bench for btc_nonce_sched
`timescale 1ns/1ps

module tb_btc_nonce_sched;

  localparam int TMO = 16;

  logic         wb_clk_i = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [31:0]  nonce_first = '0;
  logic [31:0]  nonce_last = '0;
  logic [7:0]   target_zeros = '0;
  logic         core_start;
  logic         core_pass;
  logic [31:0]  core_nonce;
  logic         core_done;
  logic [255:0] core_digest;
  logic         busy;
  logic         done;
  logic         found;
  logic         aborted;
  logic         error;
  logic [31:0]  found_nonce;
  logic [31:0]  hash_count;

  btc_nonce_sched #(.TIMEOUT(TMO)) dut (
    .wb_clk_i     (wb_clk_i),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .nonce_first  (nonce_first),
    .nonce_last   (nonce_last),
    .target_zeros (target_zeros),
    .core_start   (core_start),
    .core_pass    (core_pass),
    .core_nonce   (core_nonce),
    .core_done    (core_done),
    .core_digest  (core_digest),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .aborted      (aborted),
    .error        (error),
    .found_nonce  (found_nonce),
    .hash_count   (hash_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [31:0] first;
    logic [31:0] last;
    logic [7:0]  tz;
    logic        hit_en;
    logic [31:0] hit_nonce;
    int          lz_hit;
    int          lz_miss;
    logic        exp_found;
    logic [31:0] exp_fnonce;
    int          exp_count;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  vec_t cur;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int stop_cyc = 0;
  bit model_en = 1'b0;
  bit stop_on_done2 = 1'b0;
  logic [31:0] q_nonce [$];
  bit          q_pass [$];

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Digest with exactly k leading zero bits (k >= 256 gives all zeros).
  function automatic logic [255:0] lz_digest(input int k);
    logic [255:0] ones;
    ones = '1;
    if (k >= 256) return '0;
    return ones >> k;
  endfunction

  // Hash-core model: answers pass 0 after 3 cycles with an all-zero digest (which
  // must never be mistaken for a result) and pass 1 after 5 cycles with the digest
  // chosen by the current vector. Stops answering if the sweep is abandoned.
  initial begin : responder
    logic        rp;
    logic [31:0] rn;
    int          rlat;
    bit          rlive;
    bit          rstop;
    core_done   = 1'b0;
    core_digest = '0;
    rstop       = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      core_done   = 1'b0;
      core_digest = '0;
      if (rstop) begin
        stop  = 1'b0;
        rstop = 1'b0;
      end
      if (model_en && rst_n && core_start) begin
        rp = core_pass;
        rn = core_nonce;
        q_pass.push_back(rp);
        q_nonce.push_back(rn);
        rlat  = rp ? 5 : 3;
        rlive = 1'b1;
        for (int k = 1; k < rlat; k++) begin
          @(negedge wb_clk_i);
          if (!rst_n || !busy) rlive = 1'b0;
        end
        if (rlive) begin
          chk("nonce_hold", core_nonce, rn);
          core_done = 1'b1;
          if (rp) core_digest = (cur.hit_en && rn == cur.hit_nonce) ?
                                lz_digest(cur.lz_hit) : lz_digest(cur.lz_miss);
          else    core_digest = '0;
          if (rp && stop_on_done2) begin
            stop          = 1'b1;
            rstop         = 1'b1;
            stop_cyc      = cyc;
            stop_on_done2 = 1'b0;
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [31:0] f, input logic [31:0] l, input logic [7:0] tz);
    @(negedge wb_clk_i);
    nonce_first  = f;
    nonce_last   = l;
    target_zeros = tz;
    start        = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w;
    w = 0;
    while (!done && w < 3000) begin
      @(negedge wb_clk_i);
      w++;
    end
    if (!done) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int nl;
    cur = v;
    q_nonce.delete();
    q_pass.delete();
    model_en = 1'b1;
    pulse_start(v.first, v.last, v.tz);
    chk({tag, "_launch"}, {31'd0, core_start}, 32'd1);
    chk({tag, "_first_nonce"}, core_nonce, v.first);
    wait_done(tag);
    chk({tag, "_found"}, {31'd0, found}, {31'd0, v.exp_found});
    chk({tag, "_hash_count"}, hash_count, 32'(v.exp_count));
    chk({tag, "_aborted"}, {31'd0, aborted}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    if (v.exp_found) chk({tag, "_found_nonce"}, found_nonce, v.exp_fnonce);
    @(negedge wb_clk_i);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_launches"}, 32'(q_nonce.size()), 32'(2 * v.exp_count));
    nl = (q_nonce.size() < 2 * v.exp_count) ? q_nonce.size() : 2 * v.exp_count;
    for (int i = 0; i < nl; i++) begin
      chk($sformatf("%s_pass%0d", tag, i), {31'd0, q_pass[i]}, 32'(i % 2));
      chk($sformatf("%s_nonce%0d", tag, i), q_nonce[i], v.first + 32'(i / 2));
    end
  endtask

  initial begin : main
    int w;
    //            first         last          tz    hit  hit_nonce lzh  lzm f  fnonce cnt
    vecs[0] = '{32'd5,        32'd7,        8'd8,   1'b1, 32'd6,   8,   0,  1'b1, 32'd6,   2};
    vecs[1] = '{32'd0,        32'd3,        8'd8,   1'b0, 32'd0,   0,   7,  1'b0, 32'd0,   4};
    vecs[2] = '{32'hFFFFFFFE, 32'd1,        8'd8,   1'b0, 32'd0,   0,   0,  1'b0, 32'd0,   4};
    vecs[3] = '{32'd10,       32'd20,       8'd0,   1'b0, 32'd0,   0,   0,  1'b1, 32'd10,  1};
    vecs[4] = '{32'd1,        32'd3,        8'd9,   1'b1, 32'd2,   8,   0,  1'b0, 32'd0,   3};
    vecs[5] = '{32'd3,        32'd3,        8'd255, 1'b1, 32'd3,   255, 0,  1'b1, 32'd3,   1};
    vecs[6] = '{32'd3,        32'd3,        8'd255, 1'b1, 32'd3,   254, 0,  1'b0, 32'd0,   1};
    vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'd1,   1'b0, 32'd0,   0,   0,  1'b0, 32'd0,   1};
    vecs[8] = '{32'd100,      32'd102,      8'd8,   1'b1, 32'd102, 12,  0,  1'b1, 32'd102, 3};
    vecs[9] = '{32'd7,        32'd9,        8'd1,   1'b1, 32'd8,   1,   0,  1'b1, 32'd8,   2};
    cur = vecs[0];

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_core_start", {31'd0, core_start}, 32'd0);
    chk("rst_core_nonce", core_nonce, 32'd0);
    chk("rst_found", {31'd0, found}, 32'd0);
    chk("rst_found_nonce", found_nonce, 32'd0);
    chk("rst_hash_count", hash_count, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    chk("idle_after_rst", {31'd0, busy}, 32'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // start together with stop in IDLE: no sweep, previous results untouched
    @(negedge wb_clk_i);
    nonce_first = 32'd40;
    nonce_last  = 32'd41;
    start       = 1'b1;
    stop        = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", {31'd0, busy}, 32'd0);
    chk("startstop_launch", {31'd0, core_start}, 32'd0);
    chk("startstop_count", hash_count, 32'(vecs[NV-1].exp_count));
    // stop alone in IDLE
    stop = 1'b1;
    @(negedge wb_clk_i);
    stop = 1'b0;
    chk("idle_stop_aborted", {31'd0, aborted}, 32'd0);
    chk("idle_stop_done", {31'd0, done}, 32'd0);
    @(negedge wb_clk_i);
    chk("idle_stop_done2", {31'd0, done}, 32'd0);

    // stop in the same cycle as core_done in WAIT2
    cur = '{32'd0, 32'd5, 8'd8, 1'b0, 32'd0, 0, 0, 1'b0, 32'd0, 0};
    model_en      = 1'b1;
    stop_on_done2 = 1'b1;
    pulse_start(32'd0, 32'd5, 8'd8);
    wait_done("abort");
    chk("abort_done_lat", 32'(cyc - stop_cyc), 32'd1);
    chk("abort_aborted", {31'd0, aborted}, 32'd1);
    chk("abort_hash_count", hash_count, 32'd0);
    chk("abort_found", {31'd0, found}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge wb_clk_i);
    chk("abort_done_pulse", {31'd0, done}, 32'd0);
    repeat (8) @(negedge wb_clk_i);

    // core never answers: timeout counted from WAIT1 entry
    model_en = 1'b0;
    pulse_start(32'd0, 32'd0, 8'd8);
    chk("tmo_launch", {31'd0, core_start}, 32'd1);
    @(negedge wb_clk_i);
    w = 0;
    while (!done && w < 100) begin
      @(negedge wb_clk_i);
      w++;
    end
    chk("tmo_latency", 32'(w), 32'(TMO));
    chk("tmo_error", {31'd0, error}, 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    chk("tmo_found", {31'd0, found}, 32'd0);
    @(negedge wb_clk_i);
    chk("tmo_done_pulse", {31'd0, done}, 32'd0);

    // reset during WAIT1 of the second nonce
    cur = '{32'h55, 32'h60, 8'd8, 1'b0, 32'd0, 0, 0, 1'b0, 32'd0, 0};
    model_en = 1'b1;
    pulse_start(32'h55, 32'h60, 8'd8);
    w = 0;
    while (!(core_start && hash_count == 32'd1) && w < 500) begin
      @(negedge wb_clk_i);
      w++;
    end
    chk("rstmid_reach", {31'd0, core_start}, 32'd1);
    @(negedge wb_clk_i);
    chk("rstmid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    chk("rstmid_core_nonce", core_nonce, 32'd0);
    chk("rstmid_hash_count", hash_count, 32'd0);
    chk("rstmid_found_nonce", found_nonce, 32'd0);
    repeat (4) begin
      @(negedge wb_clk_i);
      chk("rstmid_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    chk("rstmid_idle", {31'd0, busy}, 32'd0);
    run_vec(vecs[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/btc_nonce_sched.md
BTC_NONCE_SCHED -- requirements
Module: btc_nonce_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning the maximum cycles to wait for core_done per pass before flagging an error.
REQ-002 SHALL have port wb_clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, single-cycle request to begin a nonce sweep; honoured only in IDLE.
REQ-005 SHALL have port stop, input, 1, single-cycle abort request; honoured in any non-IDLE state.
REQ-006 SHALL have ports nonce_first and nonce_last, input, 32 each, the inclusive sweep range, sampled on the accepted start.
REQ-007 SHALL have port target_zeros, input, 8, the required leading-zero bit count of the final digest, sampled on the accepted start.
REQ-008 SHALL have ports core_start (output, 1, one-cycle pass launch), core_pass (output, 1, 0 = header hash, 1 = rehash of digest) and core_nonce (output, 32, nonce under test).
REQ-009 SHALL have ports core_done (input, 1, pass-complete pulse) and core_digest (input, 256, pass result, valid with core_done).
REQ-010 SHALL have outputs busy (1), done (1, pulse), found (1), aborted (1), error (1), found_nonce (32) and hash_count (32, completed double hashes).

Function
REQ-011 SHALL implement states IDLE, LAUNCH1, WAIT1, LAUNCH2, WAIT2 and CHECK.
REQ-012 SHALL accept start in IDLE only, latch the inputs, clear found/aborted/error/hash_count, set nonce = nonce_first and enter LAUNCH1.
REQ-013 SHALL assert core_start=1 with core_pass=0 for exactly one cycle in LAUNCH1, then enter WAIT1.
REQ-014 SHALL move WAIT1 -> LAUNCH2 on core_done; LAUNCH2 asserts core_start=1 with core_pass=1 for one cycle, then enters WAIT2.
REQ-015 SHALL register core_digest on core_done in WAIT2, increment hash_count, and enter CHECK.
REQ-016 SHALL, in CHECK, declare a hit when digest bits [255 : 256-target_zeros] are all zero; target_zeros=0 always hits.
REQ-017 SHALL, on a hit, set found=1 and found_nonce=nonce, pulse done for one cycle, and return to IDLE.
REQ-018 SHALL, on a miss with nonce==nonce_last, pulse done with found=0 and return to IDLE.
REQ-019 SHALL, on any other miss, increment nonce modulo 2^32 (0xFFFFFFFF wraps to 0) and enter LAUNCH1; nonce_last < nonce_first therefore sweeps through 0.
REQ-020 SHALL hold core_nonce stable from LAUNCH1 through CHECK of each nonce.
REQ-021 SHALL drive busy=1 in every state except IDLE.
REQ-022 SHALL ignore core_done outside WAIT1/WAIT2.
REQ-023 SHALL, on stop in a non-IDLE state, set aborted=1, pulse done the next cycle, return to IDLE, and discard any core result from that cycle; stop has priority over core_done in the same cycle.
REQ-024 SHALL ignore stop in IDLE; start and stop together in IDLE SHALL start no sweep.
REQ-025 SHALL, if WAIT1 or WAIT2 lasts TIMEOUT cycles without core_done, set error=1, pulse done, and return to IDLE.
REQ-026 SHALL hold found, found_nonce, aborted, error and hash_count until the next accepted start.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE and all outputs to 0, including core_start, core_nonce, found_nonce and hash_count.
REQ-028 SHALL, on reset assertion mid-sweep, abandon the sweep immediately without a done pulse.
REQ-029 SHALL leave IDLE only after an accepted start following rst_n deassertion.

Verification
REQ-030 SHALL pass this case: first=5, last=7, target_zeros=8, model returns 0x00-prefixed digest on the second rehash -> found=1, found_nonce=6, hash_count=2, one done pulse.
REQ-031 SHALL pass this case: first=0, last=3, no digest meets target -> four double hashes, nonces 0..3 in order, done with found=0 and hash_count=4.
REQ-032 SHALL pass this case: first=0xFFFFFFFE, last=1, no hit -> core_nonce sequence FFFFFFFE, FFFFFFFF, 0, 1; hash_count=4.
REQ-033 SHALL pass this case: stop asserted in the same cycle as core_done in WAIT2 -> aborted=1, hash_count unchanged, found=0, done one cycle later.
REQ-034 SHALL pass this case: TIMEOUT=16, model never responds -> error=1 and done 16 cycles after WAIT1 entry, busy=0 afterwards.
REQ-035 SHALL pass this case: rst_n pulsed low during WAIT1 -> all outputs 0 immediately with no done pulse; a new start then runs normally.
